snn_inference_sequencer: RTL
============================

Name: snn_inference_sequencer

Overview:
- Sequences one spiking-network inference across the image SRAM, the spike queue, the two weight SRAM banks and the shared neuron datapath, for a configurable number of timesteps.
- Sits between the control register (start, abort, total_timesteps) and the datapath, and is the only driver of the datapath control strobes.
- Each timestep runs three phases: spike generation, queue drain with integration, then leak/fire.

Parameters:
- NUM_PIXELS, 196, input pixels per image (14x14).
- OUTPUTS, 10, output neurons.
- HALF_PIXELS, NUM_PIXELS/2, first pixel index stored in weight bank 1.
- TS_W, 10, timestep counter width.
- ADDR_W, 10, SRAM address width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- start  in  1  begin inference; sampled only in IDLE.
- abort  in  1  synchronous abort; return to IDLE.
- total_timesteps  in  TS_W  timesteps to run; sampled at start.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  sticky completion flag; cleared on the next accepted start.
- timestep  out  TS_W  completed-timestep count.
- pix_addr  out  ADDR_W  image SRAM read address; data returns 1 cycle later.
- pix_data  in  8  image SRAM read data.
- rand_val  in  8  RNG output.
- rand_step  out  1  advance the RNG.
- q_insert  out  1  push q_data into the spike queue.
- q_data  out  8  spiking pixel index.
- q_valid  in  1  queue non-empty; first-word-fall-through.
- q_head  in  8  queue head data, valid while q_valid.
- q_read  out  1  pop the queue head.
- w_en  out  1  weight read strobe.
- w_bank  out  1  0 = bank0, 1 = bank1.
- w_addr  out  ADDR_W  weight address; data returns 1 cycle later.
- w_data  in  8  selected-bank weight read data.
- nrn_op  out  1  0 = integrate, 1 = leak/fire.
- nrn_idx  out  4  output neuron index.
- nrn_weight  out  8  weight presented to the neuron.
- nrn_we  out  1  write the neuron result back to vmem[nrn_idx].
- nrn_spike  in  1  combinational spike from the neuron.
- spike_inc  out  1  increment spike_count[nrn_idx].

Behaviour:
- Reset: state IDLE.
  - All outputs 0.
  - Internal counters (pixel, o, idx, timestep) 0.
  - Reset mid-operation discards all progress.
  - The queue is reset externally.
- Default: every strobe (rand_step, q_insert, q_read, w_en, nrn_we, spike_inc) is 0 unless stated.
- IDLE:
  - start with total_timesteps==0: done<=1, busy stays 0, remain IDLE.
  - start with total_timesteps!=0: clear done and timestep, latch total, busy<=1, go to GEN with pix_addr=0.
- GEN (NUM_PIXELS+1 cycles):
  - Cycle k (0..NUM_PIXELS-1) drives pix_addr=k.
  - Cycle k (1..NUM_PIXELS) compares the registered index p=k-1 and asserts rand_step.
  - If rand_val < pix_data (unsigned, strict): q_insert=1, q_data=p.
  - After the compare for p=NUM_PIXELS-1, go to DRAIN.
  - Queue depth is at least NUM_PIXELS, so full is never checked.
- DRAIN:
  - q_valid=1: q_read=1, latch idx=q_head, o=0, go to FETCH.
  - q_valid=0: o=0, go to LEAK.
- FETCH:
  - w_en=1, w_bank=(idx>=HALF_PIXELS).
  - w_addr=(idx - w_bank*HALF_PIXELS)*OUTPUTS + o, computed in ADDR_W bits with no overflow for the defaults.
  - Go to INTEG.
- INTEG:
  - nrn_op=0, nrn_idx=o, nrn_weight=w_data, nrn_we=1.
  - o==OUTPUTS-1: go to DRAIN. Otherwise o++ and go to FETCH.
- LEAK:
  - nrn_op=1, nrn_idx=o, nrn_we=1, spike_inc=nrn_spike.
  - o==OUTPUTS-1: go to STEP. Otherwise o++.
- STEP:
  - timestep++.
  - New value == total: go to DONE. Otherwise go to GEN with pix_addr=0.
- DONE: done<=1, busy<=0, go to IDLE. One cycle.
- Cycles per timestep = (NUM_PIXELS+1) + 21*S + 1 + OUTPUTS + 1, where S is the spike count. With defaults this is 209+21S.
- abort (any non-IDLE state):
  - Next state IDLE, busy<=0, done unchanged.
  - No strobe is asserted in the abort cycle.
  - abort has priority over every transition.
- start while busy is ignored.
- start and abort together in IDLE: abort wins, start is ignored.
- q_insert is asserted only in GEN. q_read is asserted only in DRAIN.

Test Plan:
- total=1, all pix_data=0, rand_val=0 -> no q_insert; busy high exactly 209 cycles; done=1; timestep=1.
- total=1, pixel 5=255, others 0, rand_val=0 -> one q_insert with q_data=5; w_bank=0, w_addr 50..59 with nrn_idx 0..9; busy 230 cycles.
- Pixel 150=255 only -> w_bank=1, w_addr 520..529; pixel 97 only -> w_bank=0, w_addr 970..979.
- total=3, nrn_spike forced high only when nrn_idx==3 in LEAK -> exactly 3 spike_inc pulses, each with nrn_idx=3; timestep ends at 3.
- abort asserted in the 5th INTEG -> next cycle IDLE, busy=0, done=0, no further strobes. Repeat with wb_rst_i -> all outputs 0.
- start with total=0 -> done=1 the next cycle, busy never high. Second start while busy -> ignored; done clears only on an accepted start.

Source files
------------

// File: rtl/snn_inference_sequencer.sv
// Sequences one spiking-network inference: per timestep, spike generation, queue drain with integration, then leak/fire.
// Strobes are combinational from state; an inference takes (NUM_PIXELS+1)+21*S+1+OUTPUTS+1 cycles per timestep; abort wins over all transitions.
module snn_inference_sequencer #(
  parameter int NUM_PIXELS  = 196,
  parameter int OUTPUTS     = 10,
  parameter int HALF_PIXELS = NUM_PIXELS / 2,
  parameter int TS_W        = 10,
  parameter int ADDR_W      = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [TS_W-1:0]   total_timesteps,
  output logic              busy,
  output logic              done,
  output logic [TS_W-1:0]   timestep,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [7:0]        pix_data,
  input  logic [7:0]        rand_val,
  output logic              rand_step,
  output logic              q_insert,
  output logic [7:0]        q_data,
  input  logic              q_valid,
  input  logic [7:0]        q_head,
  output logic              q_read,
  output logic              w_en,
  output logic              w_bank,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [7:0]        w_data,
  output logic              nrn_op,
  output logic [3:0]        nrn_idx,
  output logic [7:0]        nrn_weight,
  output logic              nrn_we,
  input  logic              nrn_spike,
  output logic              spike_inc
);

  localparam int GEN_W = $clog2(NUM_PIXELS + 1);
  localparam logic [GEN_W-1:0] GEN_LAST = GEN_W'(NUM_PIXELS);
  localparam logic [3:0]       O_LAST   = 4'(OUTPUTS - 1);
  localparam logic [7:0]       HALF_IDX = 8'(HALF_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_DRAIN, S_FETCH, S_INTEG, S_LEAK, S_STEP, S_DONE
  } state_t;

  state_t            state, state_d;
  logic [GEN_W-1:0]  gen_cnt;
  logic [3:0]        o_cnt;
  logic [7:0]        idx;
  logic [TS_W-1:0]   total;
  logic [TS_W-1:0]   ts_next;
  logic              bank_c;
  logic [ADDR_W-1:0] local_idx;

  assign ts_next   = timestep + 1'b1;
  assign bank_c    = (idx >= HALF_IDX);
  assign local_idx = ADDR_W'(idx) - (bank_c ? ADDR_W'(HALF_PIXELS) : '0);

  // Kept outside the main decode so the neuron's combinational spike never loops back through it.
  assign spike_inc = (state == S_LEAK) && !abort && nrn_spike;

  always_comb begin
    state_d    = state;
    pix_addr   = '0;
    rand_step  = 1'b0;
    q_insert   = 1'b0;
    q_data     = '0;
    q_read     = 1'b0;
    w_en       = 1'b0;
    w_bank     = 1'b0;
    w_addr     = '0;
    nrn_op     = 1'b0;
    nrn_idx    = '0;
    nrn_weight = '0;
    nrn_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && total_timesteps != '0) state_d = S_GEN;
      end
      S_GEN: begin
        if (gen_cnt < GEN_LAST) pix_addr = ADDR_W'(gen_cnt);
        // pix_data now holds the pixel addressed on the previous cycle.
        if (gen_cnt != '0) begin
          rand_step = 1'b1;
          if (rand_val < pix_data) begin
            q_insert = 1'b1;
            q_data   = 8'(gen_cnt - 1'b1);
          end
        end
        if (gen_cnt == GEN_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (q_valid) begin
          q_read  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_LEAK;
        end
      end
      S_FETCH: begin
        w_en    = 1'b1;
        w_bank  = bank_c;
        w_addr  = local_idx * ADDR_W'(OUTPUTS) + ADDR_W'(o_cnt);
        state_d = S_INTEG;
      end
      S_INTEG: begin
        nrn_idx    = o_cnt;
        nrn_weight = w_data;
        nrn_we     = 1'b1;
        state_d    = (o_cnt == O_LAST) ? S_DRAIN : S_FETCH;
      end
      S_LEAK: begin
        nrn_op  = 1'b1;
        nrn_idx = o_cnt;
        nrn_we  = 1'b1;
        if (o_cnt == O_LAST) state_d = S_STEP;
      end
      S_STEP:  state_d = (ts_next == total) ? S_DONE : S_GEN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      pix_addr   = '0;
      rand_step  = 1'b0;
      q_insert   = 1'b0;
      q_data     = '0;
      q_read     = 1'b0;
      w_en       = 1'b0;
      w_bank     = 1'b0;
      w_addr     = '0;
      nrn_op     = 1'b0;
      nrn_idx    = '0;
      nrn_weight = '0;
      nrn_we     = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      timestep <= '0;
      total    <= '0;
      gen_cnt  <= '0;
      o_cnt    <= '0;
      idx      <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (total_timesteps == '0) begin
              done <= 1'b1;
            end else begin
              done     <= 1'b0;
              busy     <= 1'b1;
              timestep <= '0;
              total    <= total_timesteps;
              gen_cnt  <= '0;
            end
          end
        end
        S_GEN: gen_cnt <= gen_cnt + 1'b1;
        S_DRAIN: begin
          o_cnt <= '0;
          if (q_valid) idx <= q_head;
        end
        S_INTEG: if (o_cnt != O_LAST) o_cnt <= o_cnt + 1'b1;
        S_LEAK:  if (o_cnt != O_LAST) o_cnt <= o_cnt + 1'b1;
        S_STEP: begin
          timestep <= ts_next;
          gen_cnt  <= '0;
          // busy drops as DONE is entered so it never covers the DONE cycle.
          if (ts_next == total) busy <= 1'b0;
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
